pulse_indicator: RTL

//  Machine-to-human side of the single-pulse interface. Accepts one-cycle event pulses
//  (pipeline step, hazard, flush) and renders each as one visible LED blink of fixed

---
 rtl/pulse_indicator_if.sv | 26 ++
 rtl/pulse_indicator.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pulse_indicator_if.sv
// Event strobe in, LED drive and queue status out; master is the event source, slave the indicator.
interface pulse_indicator_if #(
    parameter int PEND_W = 4
);
    logic              pulse_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output led_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_indicator.sv
// Stretches one-cycle event strobes into ON_CYCLES LED blinks separated by OFF_CYCLES dark gaps.
// Define PULSE_INDICATOR_QUEUE_EN to queue events arriving mid-blink; otherwise they are dropped.
module pulse_indicator #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int CNT_W      = 28,
    parameter int PEND_W     = 4
) (
    input  logic               CLK,
    input  logic               clear,
    pulse_indicator_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             queued;

`ifdef PULSE_INDICATOR_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              deq;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
`ifdef PULSE_INDICATOR_QUEUE_EN
        pend_d  = pend_q;
        deq     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                accept = 1'b1;
                if (bus.pulse_in) begin
                    state_d = ST_ON;
                    cnt_d   = ON_LOAD;
                end
            end
            ST_ON: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = OFF_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    // A live strobe on the last gap cycle takes priority over the queue.
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                    if (bus.pulse_in) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                    end
`ifdef PULSE_INDICATOR_QUEUE_EN
                    else if (pend_q != '0) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                        deq     = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        queued = bus.pulse_in && !accept;

`ifdef PULSE_INDICATOR_QUEUE_EN
        if (queued && !deq) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (deq && !queued) begin
            pend_d = pend_q - 1'b1;
        end
`else
        if (queued) begin
            ovf_d = 1'b1;
        end
`endif

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PULSE_INDICATOR_QUEUE_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
`ifdef PULSE_INDICATOR_QUEUE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
`ifdef PULSE_INDICATOR_QUEUE_EN
    assign bus.pending  = pend_q;
`else
    assign bus.pending  = '0;
`endif

endmodule
